// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// ------------------
// Sits behind a Hamming(7,4) UART receiver. Each rising edge of the
// receiver's sticky valid flag (while ena=1) captures the codeword and
// sends a one-cycle active-low clear back to the receiver. The codeword
// is single-error-corrected to a nibble. Nibbles are paired into bytes,
// low nibble first, and the bytes are queued in a small FIFO for the
// consumer. If the high nibble does not arrive within TIMEOUT enabled
// cycles, the low nibble is discarded and timeout_err pulses.
//
// Handshake: out_valid is high whenever the FIFO holds a byte and
// out_data shows that byte. A byte is transferred on every rising clk
// edge where out_valid && out_ready. out_valid does not depend on
// out_ready.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          capture-side enable; freezes FSM, timer and captures
//   word_in      7-bit codeword {d4,d3,d2,p4,d1,p2,p1}
//   word_valid   receiver sticky valid level
//   rx_clr_n     one-cycle active-low clear pulse to the receiver
//   out_data     FIFO head byte
//   out_valid    FIFO not empty
//   out_ready    consumer accepts the head byte
//   fifo_count   bytes stored
//   corr_cnt     corrected-codeword count, saturating at 255
//   overflow     sticky: a byte was dropped on a full FIFO
//   timeout_err  one-cycle pulse when a low nibble is discarded
//   state_out    FSM state for debug (00 WAIT_LO, 01 WAIT_HI, 10 PUSH)

module uart_rx_frame_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [6:0]               word_in,
    input  logic                     word_valid,
    output logic                     rx_clr_n,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               corr_cnt,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [1:0]               state_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_WAIT_LO = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_PUSH    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_wv_q;
    logic            r_cap;
    logic [6:0]      r_cap_word;
    logic            r_clr_n;
    logic [3:0]      r_lo;
    logic [7:0]      r_byte;
    logic [TW-1:0]   r_to_cnt;
    logic            r_timeout_err;
    logic            r_overflow;
    logic [7:0]      r_corr;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_capture;
    logic [2:0]      w_syn;
    logic [6:0]      w_fixed;
    logic [3:0]      w_nib;
    logic            w_take;
    logic            w_lo_load;
    logic            w_byte_load;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_tmo;
    logic            w_push_req;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Rising edge of the sticky flag. word_valid_q tracks every cycle so a
    // level that rose while ena=0 is never seen as a capture later.
    assign w_capture = ena & word_valid & ~r_wv_q;

    // The captured codeword is registered first, so the FSM acts on it one
    // cycle after the capture, in the same cycle rx_clr_n is low.
    assign w_syn[0] = r_cap_word[0] ^ r_cap_word[2] ^ r_cap_word[4] ^ r_cap_word[6];
    assign w_syn[1] = r_cap_word[1] ^ r_cap_word[2] ^ r_cap_word[5] ^ r_cap_word[6];
    assign w_syn[2] = r_cap_word[3] ^ r_cap_word[4] ^ r_cap_word[5] ^ r_cap_word[6];
    assign w_fixed  = (w_syn != 3'd0) ? (r_cap_word ^ (7'd1 << (w_syn - 3'd1))) : r_cap_word;
    assign w_nib    = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};

    always_comb begin
        w_next      = r_state;
        w_take      = 1'b0;
        w_lo_load   = 1'b0;
        w_byte_load = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_tmo       = 1'b0;
        w_push_req  = 1'b0;
        if (ena) begin
            case (r_state)
                ST_WAIT_LO: begin
                    if (r_cap) begin
                        w_take    = 1'b1;
                        w_lo_load = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // A capture arriving on the last allowed cycle wins.
                    if (r_cap) begin
                        w_take      = 1'b1;
                        w_byte_load = 1'b1;
                        w_next      = ST_PUSH;
                    end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        w_tmo  = 1'b1;
                        w_next = ST_WAIT_LO;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_PUSH: begin
                    w_push_req = 1'b1;
                    w_next     = ST_WAIT_LO;
                end
                default: w_next = ST_WAIT_LO;
            endcase
        end
    end

    assign w_full = (r_count == (AW + 1)'(DEPTH));
    assign w_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_push_req & (~w_full | w_pop);
    assign w_drop = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT_LO;
            r_wv_q        <= 1'b0;
            r_cap         <= 1'b0;
            r_cap_word    <= 7'd0;
            r_clr_n       <= 1'b1;
            r_lo          <= 4'd0;
            r_byte        <= 8'd0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_overflow    <= 1'b0;
            r_corr        <= 8'd0;
        end else begin
            r_state       <= w_next;
            r_wv_q        <= word_valid;
            r_clr_n       <= ~w_capture;
            r_timeout_err <= w_tmo;
            // Pending capture is held while ena=0 or during PUSH.
            if (w_capture) begin
                r_cap      <= 1'b1;
                r_cap_word <= word_in;
            end else if (w_take) begin
                r_cap <= 1'b0;
            end
            if (w_lo_load)   r_lo   <= w_nib;
            if (w_byte_load) r_byte <= {w_nib, r_lo};
            if (w_cnt_clr) begin
                r_to_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_take && (w_syn != 3'd0) && (r_corr != 8'hFF)) r_corr <= r_corr + 8'd1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage is reset so out_data is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_byte;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign rx_clr_n    = r_clr_n;
    assign out_data    = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign fifo_count  = r_count;
    assign corr_cnt    = r_corr;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign state_out   = r_state;

endmodule
